// File: rtl/data_mem_io_pkg.sv
// Shared CPU package: peripheral window base, register offsets and TCON bit layout.
`default_nettype none

package data_mem_io_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

   localparam logic [31:0] OFF_TH      = 32'h00;
   localparam logic [31:0] OFF_TL      = 32'h04;
   localparam logic [31:0] OFF_TCON    = 32'h08;
   localparam logic [31:0] OFF_LED     = 32'h0C;
   localparam logic [31:0] OFF_DIGITS  = 32'h10;
   localparam logic [31:0] OFF_SYSTICK = 32'h14;

   localparam int TCON_EN  = 0;
   localparam int TCON_IE  = 1;
   localparam int TCON_OVF = 2;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_TH,
      SEL_TL,
      SEL_TCON,
      SEL_LED,
      SEL_DIGITS,
      SEL_SYSTICK
   } sel_e;

   function automatic sel_e decode_mmio(input logic [31:0] off);
      sel_e s;
      case (off)
         OFF_TH:      s = SEL_TH;
         OFF_TL:      s = SEL_TL;
         OFF_TCON:    s = SEL_TCON;
         OFF_LED:     s = SEL_LED;
         OFF_DIGITS:  s = SEL_DIGITS;
         OFF_SYSTICK: s = SEL_SYSTICK;
         default:     s = SEL_NONE;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_io_timer.sv
// mmio_timer: reloadable 32-bit timer (TH reload, TL count, TCON control/flag).
`default_nettype none

module mmio_timer
   import data_mem_io_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_th_i,
   input  logic        wr_tl_i,
   input  logic        wr_tcon_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] th_o,
   output logic [31:0] tl_o,
   output logic [2:0]  tcon_o,
   output logic        irq_o
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic        ovf;

   // A CPU write to TL cancels the overflow event entirely, so the flag is not set either.
   assign ovf = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF) && !wr_tl_i;

   always_comb begin
      th_d = wr_th_i ? wdata_i : th_q;

      tl_d = tl_q;
      if (wr_tl_i)
         tl_d = wdata_i;
      else if (ovf)
         tl_d = th_q;
      else if (tcon_q[TCON_EN])
         tl_d = tl_q + 32'd1;

      tcon_d = tcon_q;
      if (wr_tcon_i)
         tcon_d = wdata_i[2:0];
      else if (ovf && tcon_q[TCON_IE])
         tcon_d[TCON_OVF] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end

   assign th_o   = th_q;
   assign tl_o   = tl_q;
   assign tcon_o = tcon_q;
   assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_OVF];

endmodule

`default_nettype wire

// File: rtl/data_mem_io.sv
// data_mem_io: data RAM plus memory-mapped timer, LED, 7-segment and SysTick registers.
`default_nettype none

module data_mem_io
   import data_mem_io_pkg::*;
#(
   parameter int          RAM_WORDS = 256,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic [31:0] in_Addr,
   input  logic [31:0] in_WriteData,
   output logic [31:0] out_MemReadData,
   output logic        out_IRQ,
   output logic [7:0]  out_LED,
   output logic [11:0] out_Digits
);

   localparam int          RAM_AW    = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   logic [31:0]       ram_q [RAM_WORDS];
   logic [31:0]       word_addr;
   logic [31:0]       mmio_off;
   logic [RAM_AW-1:0] ram_idx;
   sel_e              sel;
   logic              w_unused_addr;

   logic [7:0]  led_q, led_d;
   logic [11:0] digits_q, digits_d;
   logic [31:0] systick_q, systick_d;

   logic [31:0] th, tl;
   logic [2:0]  tcon;

   assign word_addr     = {in_Addr[31:2], 2'b00};
   assign mmio_off      = word_addr - MMIO_BASE;
   assign ram_idx       = in_Addr[RAM_AW+1:2];
   assign w_unused_addr = ^in_Addr[1:0];

   always_comb begin
      sel = SEL_NONE;
      if (word_addr < RAM_BYTES)
         sel = SEL_RAM;
      else if (word_addr >= MMIO_BASE)
         sel = decode_mmio(mmio_off);
   end

   mmio_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .wr_th_i   (in_MemWrite && (sel == SEL_TH)),
      .wr_tl_i   (in_MemWrite && (sel == SEL_TL)),
      .wr_tcon_i (in_MemWrite && (sel == SEL_TCON)),
      .wdata_i   (in_WriteData),
      .th_o      (th),
      .tl_o      (tl),
      .tcon_o    (tcon),
      .irq_o     (out_IRQ)
   );

   // RAM is deliberately outside the reset domain; reset only blocks writes.
   always_ff @(posedge clk) begin
      if (!rst && in_MemWrite && (sel == SEL_RAM))
         ram_q[ram_idx] <= in_WriteData;
   end

   always_comb begin
      led_d     = led_q;
      digits_d  = digits_q;
      systick_d = systick_q + 32'd1;
      if (in_MemWrite && (sel == SEL_LED))
         led_d = in_WriteData[7:0];
      if (in_MemWrite && (sel == SEL_DIGITS))
         digits_d = in_WriteData[11:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q     <= '0;
         digits_q  <= '0;
         systick_q <= '0;
      end else begin
         led_q     <= led_d;
         digits_q  <= digits_d;
         systick_q <= systick_d;
      end
   end

   always_comb begin
      out_MemReadData = '0;
      if (in_MemRead) begin
         case (sel)
            SEL_RAM:     out_MemReadData = ram_q[ram_idx];
            SEL_TH:      out_MemReadData = th;
            SEL_TL:      out_MemReadData = tl;
            SEL_TCON:    out_MemReadData = {29'b0, tcon};
            SEL_LED:     out_MemReadData = {24'b0, led_q};
            SEL_DIGITS:  out_MemReadData = {20'b0, digits_q};
            SEL_SYSTICK: out_MemReadData = systick_q;
            default:     out_MemReadData = '0;
         endcase
      end
   end

   assign out_LED    = led_q;
   assign out_Digits = digits_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_io.sv
// Scoreboard bench for data_mem_io: stimulus queues expectations, a negedge monitor checks them.
`default_nettype none

module tb_data_mem_io;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int K_RD   = 0;
   localparam int K_IRQ  = 1;
   localparam int K_LED  = 2;
   localparam int K_DIG  = 3;
   localparam int K_TICK = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_MemRead = 1'b0;
   logic        in_MemWrite = 1'b0;
   logic [31:0] in_Addr = '0;
   logic [31:0] in_WriteData = '0;
   logic [31:0] out_MemReadData;
   logic        out_IRQ;
   logic [7:0]  out_LED;
   logic [11:0] out_Digits;

   data_mem_io dut (
      .clk             (clk),
      .rst             (rst),
      .in_MemRead      (in_MemRead),
      .in_MemWrite     (in_MemWrite),
      .in_Addr         (in_Addr),
      .in_WriteData    (in_WriteData),
      .out_MemReadData (out_MemReadData),
      .out_IRQ         (out_IRQ),
      .out_LED         (out_LED),
      .out_Digits      (out_Digits)
   );

   always #5 clk = ~clk;

   int          kq[$];
   logic [31:0] eq[$];
   string       nq[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] tb_ticks;
   int          mk;
   logic [31:0] me, ma;
   string       mn;

   // Reference SysTick: cycles since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) tb_ticks <= '0;
      else     tb_ticks <= tb_ticks + 32'd1;
   end

   always @(negedge clk) begin
      while (kq.size() > 0) begin
         mk = kq.pop_front();
         me = eq.pop_front();
         mn = nq.pop_front();
         case (mk)
            K_RD:    ma = out_MemReadData;
            K_IRQ:   ma = {31'b0, out_IRQ};
            K_LED:   ma = {24'b0, out_LED};
            K_DIG:   ma = {20'b0, out_Digits};
            default: begin ma = out_MemReadData; me = tb_ticks; end
         endcase
         n_tests++;
         if (ma !== me) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", mn, ma, me);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      in_MemRead  = 1'b0;
      in_MemWrite = 1'b0;
      in_Addr     = '0;
      in_WriteData = '0;
   endtask

   task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      in_MemRead   = r;
      in_MemWrite  = w;
      in_Addr      = a;
      in_WriteData = d;
   endtask

   task automatic chk(input int k, input logic [31:0] e, input string n);
      kq.push_back(k);
      eq.push_back(e);
      nq.push_back(n);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      op(1'b0, 1'b1, a, d);
      step();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
      op(1'b1, 1'b0, a, 32'h0);
      chk(K_RD, e, n);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      step();
      // Reset state
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'h0, "rst_tl");
      chk(K_IRQ, 32'h0, "rst_irq");
      chk(K_LED, 32'h0, "rst_led");
      chk(K_DIG, 32'h0, "rst_digits");
      step();
      rst = 1'b0;

      // RAM store then load with low address bits set
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h13, 32'hDEAD_BEEF, "ram_load_0x13");
      op(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
      chk(K_RD, 32'hDEAD_BEEF, "ram_rdw_old");
      step();
      rd(32'h10, 32'hCAFE_F00D, "ram_after_rdw");
      op(1'b0, 1'b0, 32'h10, 32'h0);
      chk(K_RD, 32'h0, "no_read_zero");
      step();

      // Unmapped, SysTick, LED, Digits
      rd(BASE + 32'h20, 32'h0, "unmapped_0x20");
      wr(BASE + 32'h18, 32'h1234_5678);
      rd(BASE + 32'h18, 32'h0, "unmapped_store");
      op(1'b1, 1'b1, BASE + 32'h14, 32'h0000_0055);
      chk(K_TICK, 32'h0, "systick_store_cycle");
      step();
      op(1'b1, 1'b0, BASE + 32'h14, 32'h0);
      chk(K_TICK, 32'h0, "systick_after_store");
      step();
      wr(BASE + 32'h0C, 32'h0000_01A5);
      op(1'b1, 1'b0, BASE + 32'h0C, 32'h0);
      chk(K_RD, 32'h0000_00A5, "led_read");
      chk(K_LED, 32'h0000_00A5, "led_out");
      step();
      wr(BASE + 32'h10, 32'hFFFF_F123);
      op(1'b1, 1'b0, BASE + 32'h10, 32'h0);
      chk(K_RD, 32'h0000_0123, "digits_read");
      chk(K_DIG, 32'h0000_0123, "digits_out");
      step();

      // Overflow with interrupt enabled
      wr(BASE + 32'h00, 32'hFFFF_FFF0);
      rd(BASE + 32'h00, 32'hFFFF_FFF0, "th_read");
      wr(BASE + 32'h04, 32'hFFFF_FFFE);
      wr(BASE + 32'h08, 32'h0000_0003);
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'hFFFF_FFFE, "tl_start");
      step();
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'hFFFF_FFFF, "tl_max");
      chk(K_IRQ, 32'h0, "irq_before_ovf");
      step();
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'hFFFF_FFF0, "tl_reload");
      chk(K_IRQ, 32'h1, "irq_set");
      step();
      op(1'b1, 1'b0, BASE + 32'h08, 32'h0);
      chk(K_RD, 32'h0000_0007, "tcon_flag");
      step();
      op(1'b1, 1'b1, BASE + 32'h08, 32'h0000_0003);
      chk(K_RD, 32'h0000_0007, "tcon_rdw_old");
      chk(K_IRQ, 32'h1, "irq_before_clear");
      step();
      op(1'b1, 1'b0, BASE + 32'h08, 32'h0);
      chk(K_RD, 32'h0000_0003, "tcon_cleared");
      chk(K_IRQ, 32'h0, "irq_cleared");
      step();

      // Overflow with interrupt disabled
      wr(BASE + 32'h08, 32'h0);
      wr(BASE + 32'h00, 32'h0000_0100);
      wr(BASE + 32'h04, 32'hFFFF_FFFF);
      wr(BASE + 32'h08, 32'h0000_0001);
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'hFFFF_FFFF, "noie_tl_max");
      step();
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'h0000_0100, "noie_reload");
      chk(K_IRQ, 32'h0, "noie_irq");
      step();
      rd(BASE + 32'h08, 32'h0000_0001, "noie_tcon");

      // Timer disabled holds TL
      wr(BASE + 32'h08, 32'h0);
      rd(BASE + 32'h04, 32'h0000_0103, "hold_tl_a");
      rd(BASE + 32'h04, 32'h0000_0103, "hold_tl_b");

      // CPU write to TL on the overflow cycle wins
      wr(BASE + 32'h00, 32'h0000_0200);
      wr(BASE + 32'h04, 32'hFFFF_FFFE);
      wr(BASE + 32'h08, 32'h0000_0003);
      step();
      wr(BASE + 32'h04, 32'h0000_0005);
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      chk(K_RD, 32'h0000_0005, "tl_write_wins");
      chk(K_IRQ, 32'h0, "tl_write_no_irq");
      step();
      rd(BASE + 32'h08, 32'h0000_0003, "tl_write_tcon");

      // Asynchronous reset mid-count; RAM survives and is write-protected
      wr(32'h20, 32'h1234_5678);
      wr(32'h24, 32'hAAAA_0000);
      wr(BASE + 32'h0C, 32'h0000_003C);
      wr(BASE + 32'h10, 32'h0000_0ABC);
      op(1'b1, 1'b0, BASE + 32'h04, 32'h0);
      #1;
      rst = 1'b1;
      #1;
      n_tests++;
      if (out_LED !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_led_immediate: got %h expected 00", out_LED);
      end
      n_tests++;
      if (out_Digits !== 12'h000) begin
         n_fail++;
         $display("FAIL arst_digits_immediate: got %h expected 000", out_Digits);
      end
      n_tests++;
      if (out_IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_irq_immediate: got %b expected 0", out_IRQ);
      end
      n_tests++;
      if (out_MemReadData !== 32'h0) begin
         n_fail++;
         $display("FAIL arst_tl_immediate: got %h expected 0", out_MemReadData);
      end
      chk(K_RD, 32'h0, "arst_tl");
      chk(K_LED, 32'h0, "arst_led");
      chk(K_DIG, 32'h0, "arst_digits");
      chk(K_IRQ, 32'h0, "arst_irq");
      step();
      op(1'b1, 1'b1, 32'h24, 32'h0BAD_0000);
      chk(K_RD, 32'hAAAA_0000, "ram_during_rst");
      step();
      rd(32'h20, 32'h1234_5678, "ram_kept_20");
      rst = 1'b0;
      rd(32'h24, 32'hAAAA_0000, "ram_wr_blocked");
      rd(BASE + 32'h08, 32'h0, "tcon_after_rst");
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 256, data RAM depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'h4000_0000, base of the peripheral window.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_MemRead  input  1  load request from EX/MEM.
REQ-006 The block SHALL have port in_MemWrite  input  1  store request from EX/MEM.
REQ-007 The block SHALL have port in_Addr  input  32  byte address (the ALU result).
REQ-008 The block SHALL have port in_WriteData  input  32  store data.
REQ-009 The block SHALL have port out_MemReadData  output  32  load data, driven to the MEM/WB register's in_MemReadData.
REQ-010 The block SHALL have port out_IRQ  output  1  timer interrupt request.
REQ-011 The block SHALL have port out_LED  output  8  LED register.
REQ-012 The block SHALL have port out_Digits  output  12  7-segment register (anode select [11:8], segments [7:0]).

Function
REQ-013 Address decode SHALL ignore in_Addr[1:0]; RAM space is in_Addr < 4*RAM_WORDS, indexed by in_Addr[log2(RAM_WORDS)+1:2].
REQ-014 MMIO map, offsets from MMIO_BASE: 0x00 TH (RW), 0x04 TL (RW), 0x08 TCON[2:0] (RW), 0x0C LED[7:0] (RW), 0x10 Digits[11:0] (RW), 0x14 SysTick (RO).
REQ-015 Reads SHALL be combinational, the same cycle as in_MemRead; out_MemReadData SHALL be 0 when in_MemRead=0, and also for unmapped addresses.
REQ-016 Register fields narrower than 32 bits SHALL read zero-extended.
REQ-017 Writes SHALL take effect at the rising edge with in_MemWrite=1; writes to unmapped addresses and to SysTick SHALL be ignored.
REQ-018 If in_MemRead and in_MemWrite are both 1, the read SHALL return the pre-write value.
REQ-019 SysTick SHALL increment by 1 every cycle out of reset and wrap from 32'hFFFF_FFFF to 0.
REQ-020 Timer: with TCON[0]=1, TL SHALL increment by 1 each cycle.
REQ-021 Timer overflow: with TCON[0]=1 and TL=32'hFFFF_FFFF, TL SHALL load TH at the next edge; TCON[2] SHALL set at the same edge if TCON[1]=1.
REQ-022 With TCON[0]=0, TL and TCON[2] SHALL hold.
REQ-023 A CPU write to TL or TCON in the same cycle as an increment or overflow SHALL win completely; the hardware update for that register is discarded that cycle.
REQ-024 TCON[2] SHALL clear only by a CPU write of 0 to bit 2.
REQ-025 out_IRQ SHALL equal TCON[1] & TCON[2], combinational from registers.
REQ-026 out_LED and out_Digits SHALL be direct register outputs with no combinational path from inputs.

Reset
REQ-027 On rst=1, TH, TL, TCON, LED, Digits and SysTick SHALL clear to 0 asynchronously, giving out_IRQ=0, out_LED=0 and out_Digits=0.
REQ-028 RAM contents SHALL NOT be reset; RAM writes SHALL be blocked while rst=1.
REQ-029 A reset asserted mid-count SHALL abort the timer with no overflow and no IRQ.

Structure
REQ-030 MMIO_BASE, the register offsets and the TCON bit indices SHALL reside in the shared CPU package.
REQ-031 TH, TL and TCON SHALL be one sub-module, mmio_timer; RAM, decode, LED, Digits and SysTick stay in data_mem_io.

Verification
REQ-032 Store 32'hDEADBEEF to 0x0000_0010, then load 0x0000_0013 -> out_MemReadData=32'hDEADBEEF in the load cycle.
REQ-033 TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011 -> TL overflows after 2 cycles, reloads to FFFF_FFF0; out_IRQ=1 next cycle; a later TCON write of 3'b011 clears it.
REQ-034 TCON=3'b001 with overflow -> TL reloads and out_IRQ stays 0.
REQ-035 A TL write of 5 on the overflow cycle -> TL=5, TCON[2] unchanged.
REQ-036 Load 0x4000_0020 -> 0; store to SysTick -> ignored, the count continues; load LED after a store of 0x1A5 -> 0xA5.
REQ-037 Assert rst asynchronously while counting -> registers 0 immediately without a clock edge; RAM data written beforehand still reads back.
